// File: rtl/vrow_ctrl.sv
// Vertical row controller: turns vcount's per-line flags into sync/visible levels,
// glyph/character row counters, the row base address and one fetch request per row.
module vrow_ctrl #(
    parameter int unsigned TEXT_COLS = 80,
    parameter int unsigned TEXT_ROWS = 30,
    parameter int unsigned GLYPH_H   = 16,
    parameter int unsigned ADDR_W    = 13,
    parameter logic        VSYNC_POL = 1'b0
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              vCountIncr,
    input  logic              vBeginPulse,
    input  logic              vEndPulse,
    input  logic              vVisEnd,
    input  logic              vCountEnd,
    input  logic              fetchAck,
    output logic              vSync,
    output logic              vVisible,
    output logic [3:0]        glyphRow,
    output logic [4:0]        charRow,
    output logic [ADDR_W-1:0] rowBaseAddr,
    output logic              fetchReq,
    output logic [ADDR_W-1:0] fetchAddr,
    output logic              frameStart,
    output logic              fetchOverrun
);

    localparam logic [3:0]        GLYPH_LAST = 4'(GLYPH_H - 1);
    localparam logic [4:0]        ROW_LAST   = 5'(TEXT_ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_INC   = ADDR_W'(TEXT_COLS);

    logic              vsync_q,       vsync_d;
    logic              visible_q,     visible_d;
    logic [3:0]        glyph_row_q,   glyph_row_d;
    logic [4:0]        char_row_q,    char_row_d;
    logic [ADDR_W-1:0] row_base_q,    row_base_d;
    logic              fetch_req_q,   fetch_req_d;
    logic [ADDR_W-1:0] fetch_addr_q,  fetch_addr_d;
    logic              frame_start_q, frame_start_d;
    logic              overrun_q,     overrun_d;
    logic              trig;

    always_comb begin
        vsync_d       = vsync_q;
        visible_d     = visible_q;
        glyph_row_d   = glyph_row_q;
        char_row_d    = char_row_q;
        row_base_d    = row_base_q;
        fetch_req_d   = fetch_req_q;
        fetch_addr_d  = fetch_addr_q;
        frame_start_d = 1'b0;
        overrun_d     = overrun_q;
        trig          = 1'b0;

        // End of sync takes priority over begin when both flags are high.
        if (vEndPulse) begin
            vsync_d = ~VSYNC_POL;
        end else if (vBeginPulse) begin
            vsync_d = VSYNC_POL;
        end

        if (vCountIncr) begin
            if (vCountEnd) begin
                visible_d     = 1'b1;
                glyph_row_d   = '0;
                char_row_d    = '0;
                row_base_d    = '0;
                frame_start_d = 1'b1;
                trig          = 1'b1;
            end else if (vVisEnd) begin
                visible_d = 1'b0;
            end else if (visible_q) begin
                if (glyph_row_q < GLYPH_LAST) begin
                    glyph_row_d = glyph_row_q + 4'd1;
                end else begin
                    glyph_row_d = '0;
                    if (char_row_q < ROW_LAST) begin
                        char_row_d = char_row_q + 5'd1;
                        row_base_d = row_base_q + COLS_INC;
                        trig       = 1'b1;
                    end
                end
            end
        end

        // A new trigger supersedes an ack landing on the same edge.
        if (trig) begin
            fetch_req_d  = 1'b1;
            fetch_addr_d = row_base_d;
            if (fetch_req_q && !fetchAck) begin
                overrun_d = 1'b1;
            end
        end else if (fetch_req_q && fetchAck) begin
            fetch_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            vsync_q       <= ~VSYNC_POL;
            visible_q     <= 1'b0;
            glyph_row_q   <= '0;
            char_row_q    <= '0;
            row_base_q    <= '0;
            fetch_req_q   <= 1'b0;
            fetch_addr_q  <= '0;
            frame_start_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            vsync_q       <= vsync_d;
            visible_q     <= visible_d;
            glyph_row_q   <= glyph_row_d;
            char_row_q    <= char_row_d;
            row_base_q    <= row_base_d;
            fetch_req_q   <= fetch_req_d;
            fetch_addr_q  <= fetch_addr_d;
            frame_start_q <= frame_start_d;
            overrun_q     <= overrun_d;
        end
    end

    assign vSync        = vsync_q;
    assign vVisible     = visible_q;
    assign glyphRow     = glyph_row_q;
    assign charRow      = char_row_q;
    assign rowBaseAddr  = row_base_q;
    assign fetchReq     = fetch_req_q;
    assign fetchAddr    = fetch_addr_q;
    assign frameStart   = frame_start_q;
    assign fetchOverrun = overrun_q;

endmodule

// File: tb/tb_vrow_ctrl.sv
// Bench for vrow_ctrl: an emulated 525-line vcount with random line lengths and
// random fetch acks, checked every clock against a line-number based reference.
module tb_vrow_ctrl;

    localparam int LINES     = 525;
    localparam int VIS_LINES = 480;
    localparam int GLYPH     = 16;
    localparam int COLS      = 80;
    localparam int ROWS      = 30;
    localparam int VS_BEGIN  = 490;
    localparam int VS_END    = 492;

    logic        clk = 1'b0;
    logic        nrst;
    logic        vCountIncr, vBeginPulse, vEndPulse, vVisEnd, vCountEnd, fetchAck;
    logic        vSync, vVisible, fetchReq, frameStart, fetchOverrun;
    logic [3:0]  glyphRow;
    logic [4:0]  charRow;
    logic [12:0] rowBaseAddr, fetchAddr;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // emulated vcount
    int          line = LINES - 1;
    int          clk_in_line = 0;
    int unsigned line_len = 2;

    // reference state
    bit seen_wrap = 0;
    bit m_vsync = 0;
    bit m_fs = 0;
    bit m_pend = 0;
    int m_addr = 0;
    bit m_ovr = 0;
    bit obs_req = 0;
    bit frame_valid = 0;
    int completions = 0;
    int frames = 0;
    int pend_clks = 0;
    bit ack_hold = 0;

    always #5 clk = ~clk;

    vrow_ctrl #(
        .TEXT_COLS(80),
        .TEXT_ROWS(30),
        .GLYPH_H  (16),
        .ADDR_W   (13),
        .VSYNC_POL(1'b0)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .vCountIncr  (vCountIncr),
        .vBeginPulse (vBeginPulse),
        .vEndPulse   (vEndPulse),
        .vVisEnd     (vVisEnd),
        .vCountEnd   (vCountEnd),
        .fetchAck    (fetchAck),
        .vSync       (vSync),
        .vVisible    (vVisible),
        .glyphRow    (glyphRow),
        .charRow     (charRow),
        .rowBaseAddr (rowBaseAddr),
        .fetchReq    (fetchReq),
        .fetchAddr   (fetchAddr),
        .frameStart  (frameStart),
        .fetchOverrun(fetchOverrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (line %0d, t=%0t)", tag, got, exp, line, $time);
        end
    endtask

    task automatic set_flags();
        vBeginPulse = (line == VS_BEGIN);
        vEndPulse   = (line == VS_END);
        vVisEnd     = (line == VIS_LINES - 1);
        vCountEnd   = (line == LINES - 1);
    endtask

    // One clock: advance the reference for the edge, compare every output, drive next inputs.
    task automatic step();
        bit incr_s, ack_s, rst_s, trig;
        int line_s, taddr, l, exp_g, exp_c;
        incr_s = vCountIncr;
        ack_s  = fetchAck;
        rst_s  = !nrst;
        line_s = line;
        trig   = 0;
        taddr  = 0;
        @(posedge clk);
        #1;
        if (incr_s) line = (line_s == LINES - 1) ? 0 : line_s + 1;
        if (rst_s) begin
            seen_wrap   = 0;
            m_vsync     = 0;
            m_fs        = 0;
            m_pend      = 0;
            m_addr      = 0;
            m_ovr       = 0;
            frame_valid = 0;
        end else begin
            if (obs_req && ack_s) completions++;
            if (line_s == VS_END) m_vsync = 0;
            else if (line_s == VS_BEGIN) m_vsync = 1;
            m_fs = 0;
            if (incr_s && line == 0) begin
                if (frame_valid) check("frame_fetches", completions, ROWS);
                frame_valid = 1;
                completions = 0;
                frames++;
                seen_wrap = 1;
                m_fs  = 1;
                trig  = 1;
                taddr = 0;
            end else if (incr_s && seen_wrap && line < VIS_LINES && line % GLYPH == 0) begin
                trig  = 1;
                taddr = (line / GLYPH) * COLS;
            end
            if (trig) begin
                if (m_pend && !ack_s) begin
                    m_ovr = 1;
                    frame_valid = 0;
                end
                m_pend = 1;
                m_addr = taddr;
            end else if (m_pend && ack_s) begin
                m_pend = 0;
            end
        end

        if (!seen_wrap) begin
            exp_g = 0;
            exp_c = 0;
        end else begin
            l = (line < VIS_LINES) ? line : VIS_LINES - 1;
            exp_g = l % GLYPH;
            exp_c = l / GLYPH;
            if (exp_c > ROWS - 1) exp_c = ROWS - 1;
        end
        check("vSync",        vSync,        m_vsync ? 0 : 1);
        check("vVisible",     vVisible,     (seen_wrap && line < VIS_LINES) ? 1 : 0);
        check("glyphRow",     glyphRow,     exp_g);
        check("charRow",      charRow,      exp_c);
        check("rowBaseAddr",  rowBaseAddr,  exp_c * COLS);
        check("frameStart",   frameStart,   m_fs);
        check("fetchReq",     fetchReq,     m_pend);
        check("fetchAddr",    fetchAddr,    m_addr);
        check("fetchOverrun", fetchOverrun, m_ovr);
        obs_req = fetchReq;

        if (incr_s) begin
            clk_in_line = 0;
            line_len = $urandom_range(1, 3);
        end else begin
            clk_in_line++;
        end
        vCountIncr = (clk_in_line == int'(line_len) - 1);
        set_flags();
        if (m_pend) pend_clks++;
        else pend_clks = 0;
        fetchAck = !ack_hold && (pend_clks >= 6 || $urandom_range(0, 2) == 0);
    endtask

    task automatic run_to_line(input int target);
        int n = 0;
        while (line != target && n < 5000) begin
            step();
            n++;
        end
        if (line != target) check("wait_line", line, target);
    endtask

    task automatic run_frames(input int count);
        int target = frames + count;
        int n = 0;
        while (frames < target && n < 2000 * count) begin
            step();
            n++;
        end
        if (frames < target) check("wait_frames", frames, target);
    endtask

    initial begin
        nrst       = 1'b0;
        vCountIncr = 1'b0;
        fetchAck   = 1'b0;
        set_flags();
        repeat (3) step();
        nrst = 1'b1;

        run_frames(3);

        // hold off acks across several row triggers
        run_to_line(100);
        ack_hold = 1;
        run_to_line(150);
        check("overrun_sticky", fetchOverrun, 1);
        check("overrun_req",    fetchReq,     1);
        check("overrun_addr",   fetchAddr,    9 * COLS);
        ack_hold = 0;

        // reset while a fetch is pending and vsync is active
        run_to_line(460);
        ack_hold = 1;
        run_to_line(491);
        check("vsync_active",    vSync,    0);
        check("pend_before_rst", fetchReq, 1);
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        check("rst_vsync", vSync,        1);
        check("rst_req",   fetchReq,     0);
        check("rst_ovr",   fetchOverrun, 0);
        ack_hold = 0;

        run_frames(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
